mpsoc_msi_ahb3_slave_arbiter: RTL and testbench

Per-slave-port arbiter for the AHB3 multi-master interconnect. It decides which master owns one slave port's address phase, and it tracks which master owns the following data phase.
Priority-based selection with round-robin tie-break. Honours HMASTLOCK, the master port's can_switch, and slave HREADY.
One instance per slave port. Its grant vector drives the address/data muxes and is returned to the master ports as master_granted.

---
 rtl/mpsoc_msi_ahb3_slave_arbiter.sv | 153 +++++++++++++++
 tb/tb_mpsoc_msi_ahb3_slave_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_msi_ahb3_slave_arbiter.sv
// Per-slave-port AHB3 arbiter: highest priority wins, ties resolved round-robin,
// with HMASTLOCK / burst-boundary hold-off and data-phase owner tracking.
module mpsoc_msi_ahb3_slave_arbiter #(
  parameter int MASTERS = 5,
  parameter int IDXW    = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [3*MASTERS-1:0]   mst_priority,
  input  logic [MASTERS-1:0]     mst_HSEL,
  input  logic [2*MASTERS-1:0]   mst_HTRANS,
  input  logic [MASTERS-1:0]     mst_HMASTLOCK,
  input  logic [MASTERS-1:0]     can_switch,
  input  logic                   slv_HREADY,
  output logic [MASTERS-1:0]     granted_master,
  output logic [IDXW-1:0]        granted_idx,
  output logic [MASTERS-1:0]     data_master,
  output logic [1:0]             arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OWNED  = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_t;

  logic [MASTERS-1:0] r_grant;
  logic [IDXW-1:0]    r_idx;
  logic [IDXW-1:0]    r_rr;
  logic [MASTERS-1:0] r_data;
  arb_state_t         r_state;

  logic [MASTERS-1:0] w_req;
  logic               w_own;
  logic               w_owner_req;
  logic               w_owner_lock;
  logic               w_owner_cs;
  logic               w_switch_ok;
  logic               w_found;
  logic [2:0]         w_best_prio;
  logic [IDXW-1:0]    w_win_idx;
  logic [MASTERS-1:0] w_win_onehot;
  logic [MASTERS-1:0] w_nxt_grant;
  logic [IDXW-1:0]    w_nxt_idx;
  logic [IDXW-1:0]    w_nxt_rr;
  logic [MASTERS-1:0] w_nxt_data;
  arb_state_t         w_nxt_state;

  // Only NONSEQ/SEQ transfers to this port count as requests.
  always_comb begin
    w_req = '0;
    for (int m = 0; m < MASTERS; m++) begin
      w_req[m] = mst_HSEL[m] & mst_HTRANS[2*m+1];
    end
  end

  assign w_own        = |r_grant;
  assign w_owner_req  = w_req[r_idx];
  assign w_owner_lock = mst_HMASTLOCK[r_idx];
  assign w_owner_cs   = can_switch[r_idx];
  assign w_switch_ok  = slv_HREADY & ~(w_own & w_owner_lock) &
                        (~w_own | ~w_owner_req | w_owner_cs);

  // Winner: max priority; among equals, the smallest cyclic distance from rr.
  always_comb begin
    int d;
    int best_d;
    w_found     = 1'b0;
    w_best_prio = 3'd0;
    w_win_idx   = '0;
    best_d      = 0;
    d           = 0;
    for (int m = 0; m < MASTERS; m++) begin
      d = (m >= int'(r_rr)) ? (m - int'(r_rr)) : (m + MASTERS - int'(r_rr));
      if (w_req[m] && (!w_found || (mst_priority[3*m +: 3] > w_best_prio) ||
                       ((mst_priority[3*m +: 3] == w_best_prio) && (d < best_d)))) begin
        w_found     = 1'b1;
        w_best_prio = mst_priority[3*m +: 3];
        best_d      = d;
        w_win_idx   = IDXW'(m);
      end else begin
        w_found     = w_found;
      end
    end
  end

  // One-hot expansion of the winner index.
  always_comb begin
    w_win_onehot = '0;
    for (int m = 0; m < MASTERS; m++) begin
      w_win_onehot[m] = (int'(w_win_idx) == m);
    end
  end

  // Next grant / round-robin pointer; parked when nothing is requesting.
  always_comb begin
    w_nxt_grant = r_grant;
    w_nxt_idx   = r_idx;
    w_nxt_rr    = r_rr;
    if (w_switch_ok && w_found) begin
      w_nxt_grant = w_win_onehot;
      w_nxt_idx   = w_win_idx;
      w_nxt_rr    = (int'(w_win_idx) == (MASTERS - 1)) ? '0 : (w_win_idx + IDXW'(1));
    end else begin
      w_nxt_grant = r_grant;
    end
  end

  // Status of the owner that will hold the bus after this edge; lock dominates.
  always_comb begin
    w_nxt_state = ST_IDLE;
    if (!(|w_nxt_grant)) begin
      w_nxt_state = ST_IDLE;
    end else if (mst_HMASTLOCK[w_nxt_idx]) begin
      w_nxt_state = ST_LOCKED;
    end else if (w_req[w_nxt_idx]) begin
      w_nxt_state = ST_OWNED;
    end else begin
      w_nxt_state = ST_IDLE;
    end
  end

  assign w_nxt_data = w_owner_req ? r_grant : '0;

  // Arbiter state; everything freezes while the slave stalls.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant <= '0;
      r_idx   <= '0;
      r_rr    <= '0;
      r_data  <= '0;
      r_state <= ST_IDLE;
    end else if (slv_HREADY) begin
      r_grant <= w_nxt_grant;
      r_idx   <= w_nxt_idx;
      r_rr    <= w_nxt_rr;
      r_data  <= w_nxt_data;
      r_state <= w_nxt_state;
    end else begin
      r_grant <= r_grant;
      r_idx   <= r_idx;
      r_rr    <= r_rr;
      r_data  <= r_data;
      r_state <= r_state;
    end
  end

  assign granted_master = r_grant;
  assign granted_idx    = r_idx;
  assign data_master    = r_data;
  assign arb_state      = r_state;

endmodule

// File: tb/tb_mpsoc_msi_ahb3_slave_arbiter.sv
// Bench for the AHB3 slave-port arbiter: table vectors, directed corner
// sequences and random traffic against a behavioural reference model.
module tb_mpsoc_msi_ahb3_slave_arbiter;

  localparam int M = 5;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [14:0] pri;
  logic [4:0]  sel;
  logic [9:0]  trans;
  logic [4:0]  lock;
  logic [4:0]  cs;
  logic        rdy;
  logic [4:0]  granted_master;
  logic [2:0]  granted_idx;
  logic [4:0]  data_master;
  logic [1:0]  arb_state;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: -1 means "nobody"
  int         m_owner;
  int         m_rr;
  int         m_data;
  logic [1:0] m_state;

  typedef struct {
    string       nm;
    logic [4:0]  rq;
    logic [14:0] pr;
    logic [4:0]  lk;
    logic [4:0]  sw;
    logic        rd;
    logic [4:0]  eg;
    logic [4:0]  ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[10];

  mpsoc_msi_ahb3_slave_arbiter #(.MASTERS(M)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .mst_priority   (pri),
    .mst_HSEL       (sel),
    .mst_HTRANS     (trans),
    .mst_HMASTLOCK  (lock),
    .can_switch     (cs),
    .slv_HREADY     (rdy),
    .granted_master (granted_master),
    .granted_idx    (granted_idx),
    .data_master    (data_master),
    .arb_state      (arb_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit req_of(int i);
    return sel[i] && trans[2*i+1];
  endfunction

  function automatic int prio_of(int i);
    return int'(pri[3*i +: 3]);
  endfunction

  function automatic logic [31:0] oh(int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  // Scan cyclically from rr, keeping the first requester with the strictly best priority.
  function automatic int model_winner();
    int best = -1;
    for (int k = 0; k < M; k++) begin
      int i = (m_rr + k) % M;
      if (req_of(i) && (best < 0 || prio_of(i) > prio_of(best))) best = i;
    end
    return best;
  endfunction

  task automatic model_step();
    int  o;
    bit  own;
    bit  sw;
    int  w;
    int  nd;
    if (!rdy) return;
    o   = m_owner;
    own = (o >= 0);
    nd  = (own && req_of(o)) ? o : -1;
    if (own) sw = !lock[o] && (!req_of(o) || cs[o]);
    else     sw = 1'b1;
    if (sw) begin
      w = model_winner();
      if (w >= 0) begin
        m_owner = w;
        m_rr    = (w + 1) % M;
      end
    end
    if (m_owner < 0)            m_state = 2'b00;
    else if (lock[m_owner])     m_state = 2'b10;
    else if (req_of(m_owner))   m_state = 2'b01;
    else                        m_state = 2'b00;
    m_data = nd;
  endtask

  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
    chk("model_grant", {27'd0, granted_master}, oh(m_owner));
    chk("model_idx",   {29'd0, granted_idx}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_data",  {27'd0, data_master}, oh(m_data));
    chk("model_state", {30'd0, arb_state}, {30'd0, m_state});
  endtask

  task automatic set_req(input logic [4:0] mask);
    sel = mask;
    for (int i = 0; i < M; i++) trans[2*i +: 2] = mask[i] ? 2'b10 : 2'b00;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    HRESET = 1'b1;
    #1;
    m_owner = -1; m_rr = 0; m_data = -1; m_state = 2'b00;
    chk("rst_grant", {27'd0, granted_master}, 32'd0);
    chk("rst_idx",   {29'd0, granted_idx}, 32'd0);
    chk("rst_data",  {27'd0, data_master}, 32'd0);
    chk("rst_state", {30'd0, arb_state}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b0;
    pri = '0; lock = '0; cs = '0; rdy = 1'b1;
    set_req(5'b00000);
    #2;
    do_reset();

    // Round-robin among equal priorities, then priority selection, then parking.
    tbl[0] = '{"rr_m0",    5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b00000, 1'b1, 5'b00001, 5'b00000, 2'b01};
    tbl[1] = '{"rr_hold",  5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b00000, 1'b1, 5'b00001, 5'b00001, 2'b01};
    tbl[2] = '{"rr_m2",    5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b00001, 1'b1, 5'b00100, 5'b00001, 2'b01};
    tbl[3] = '{"rr_hold2", 5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b00000, 1'b1, 5'b00100, 5'b00100, 2'b01};
    tbl[4] = '{"rr_m4",    5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b00100, 1'b1, 5'b10000, 5'b00100, 2'b01};
    tbl[5] = '{"rr_wrap",  5'b10101, 15'b010_010_010_010_010, 5'b0, 5'b10000, 1'b1, 5'b00001, 5'b10000, 2'b01};
    tbl[6] = '{"prio_m3",  5'b01010, 15'b000_101_000_011_000, 5'b0, 5'b00000, 1'b1, 5'b01000, 5'b00000, 2'b01};
    tbl[7] = '{"prio_dat", 5'b01010, 15'b000_101_000_011_000, 5'b0, 5'b00000, 1'b1, 5'b01000, 5'b01000, 2'b01};
    tbl[8] = '{"park",     5'b00000, 15'b000_101_000_011_000, 5'b0, 5'b00000, 1'b1, 5'b01000, 5'b00000, 2'b00};
    tbl[9] = '{"park2",    5'b00000, 15'b000_101_000_011_000, 5'b0, 5'b11111, 1'b1, 5'b01000, 5'b00000, 2'b00};

    for (int v = 0; v < 10; v++) begin
      set_req(tbl[v].rq);
      pri = tbl[v].pr; lock = tbl[v].lk; cs = tbl[v].sw; rdy = tbl[v].rd;
      tick();
      chk({tbl[v].nm, "_grant"}, {27'd0, granted_master}, {27'd0, tbl[v].eg});
      chk({tbl[v].nm, "_data"},  {27'd0, data_master},    {27'd0, tbl[v].ed});
      chk({tbl[v].nm, "_state"}, {30'd0, arb_state},      {30'd0, tbl[v].es});
    end
    chk("prio_m3_idx", {29'd0, granted_idx}, 32'd3);

    // Locked owner issuing IDLE keeps the bus against a priority-7 request.
    do_reset();
    set_req(5'b00100); pri = 15'b000_000_011_000_000; lock = 5'b00100; cs = 5'b00000; rdy = 1'b1;
    tick();
    chk("lock_grant", {27'd0, granted_master}, 32'h04);
    chk("lock_state", {30'd0, arb_state}, 32'd2);
    sel = 5'b10100; trans = 10'b10_00_00_00_00; pri = 15'b111_000_011_000_000; cs = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lock_hold", {27'd0, granted_master}, 32'h04);
      chk("lock_hold_state", {30'd0, arb_state}, 32'd2);
    end
    lock = 5'b00000;
    tick();
    chk("unlock_grant", {27'd0, granted_master}, 32'h10);
    chk("unlock_idx", {29'd0, granted_idx}, 32'd4);
    chk("unlock_state", {30'd0, arb_state}, 32'd1);

    // Owner mid-burst (can_switch low) plus an HREADY stall blocks preemption.
    do_reset();
    set_req(5'b00010); pri = 15'b000_000_000_001_000; lock = '0; cs = 5'b00000; rdy = 1'b1;
    tick();
    chk("burst_grant", {27'd0, granted_master}, 32'h02);
    set_req(5'b00011); pri = 15'b000_000_000_001_111;
    tick();
    chk("no_preempt", {27'd0, granted_master}, 32'h02);
    chk("no_preempt_data", {27'd0, data_master}, 32'h02);
    rdy = 1'b0; cs = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_grant", {27'd0, granted_master}, 32'h02);
      chk("stall_data", {27'd0, data_master}, 32'h02);
    end
    rdy = 1'b1;
    tick();
    chk("after_stall", {27'd0, granted_master}, 32'h01);
    chk("after_stall_idx", {29'd0, granted_idx}, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      sel = 5'($urandom);
      trans = 10'($urandom);
      for (int i = 0; i < M; i++) pri[3*i +: 3] = 3'($urandom_range(0, 3));
      lock = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b00000;
      cs = 5'($urandom);
      tick();
    end

    // Reset mid-burst takes effect without a clock edge.
    rdy = 1'b1; lock = '0; cs = '0; pri = 15'b000_000_001_000_000;
    set_req(5'b00000);
    tick();
    do_reset();
    set_req(5'b00100);
    tick();
    tick();
    chk("burst_owner", {27'd0, granted_master}, 32'h04);
    #2;
    do_reset();
    set_req(5'b00000);
    tick();
    chk("post_rst_state", {30'd0, arb_state}, 32'd0);
    chk("post_rst_grant", {27'd0, granted_master}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
